// File: rtl/ccc_config_updater.sv
`default_nettype none
// ============================================================================
// Module      : ccc_config_updater
// Description : Target-side CCC payload decoder. Collects the data bytes of
//               SETMWL / SETMRL / SETDASA / SETNEWDA / RSTDAA and turns a
//               well-formed CCC into a single-cycle update of the limits in
//               the configuration block or of the dynamic address CSR.
//               Malformed or abandoned CCCs never touch configuration state.
// Revision    : 1.0 - initial release
// ============================================================================
module ccc_config_updater #(
    parameter int MAX_PAYLOAD = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ccc_valid_i,
    input  logic [7:0]  ccc_code_i,
    input  logic        direct_sel_i,
    input  logic        data_valid_i,
    input  logic [7:0]  data_i,
    input  logic        data_last_i,
    input  logic        ccc_end_i,
    input  logic        target_sta_addr_valid_i,
    input  logic        target_dyn_addr_valid_i,
    output logic        set_mwl_o,
    output logic [15:0] mwl_o,
    output logic        set_mrl_o,
    output logic [15:0] mrl_o,
    output logic        set_ibil_o,
    output logic [7:0]  ibil_o,
    output logic        dyn_addr_we_o,
    output logic [6:0]  dyn_addr_o,
    output logic        dyn_addr_valid_o,
    output logic        ccc_err_o,
    output logic        busy_o
);

    // The buffer always holds at least three bytes so the SETMRL decode can
    // address b2 whatever MAX_PAYLOAD is set to.
    localparam int BUF_DEPTH = (MAX_PAYLOAD > 3) ? MAX_PAYLOAD : 3;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_THREE = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PAYLOAD);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    localparam logic [7:0] CCC_RSTDAA   = 8'h06;
    localparam logic [7:0] CCC_SETMWL_B = 8'h09;
    localparam logic [7:0] CCC_SETMRL_B = 8'h0A;
    localparam logic [7:0] CCC_SETDASA  = 8'h87;
    localparam logic [7:0] CCC_SETNEWDA = 8'h88;
    localparam logic [7:0] CCC_SETMWL_D = 8'h89;
    localparam logic [7:0] CCC_SETMRL_D = 8'h8A;

    function automatic logic is_supported(input logic [7:0] c);
        case (c)
            CCC_RSTDAA, CCC_SETMWL_B, CCC_SETMRL_B, CCC_SETDASA,
            CCC_SETNEWDA, CCC_SETMWL_D, CCC_SETMRL_D: is_supported = 1'b1;
            default:                                  is_supported = 1'b0;
        endcase
    endfunction

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [7:0]       code;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       payload [BUF_DEPTH];

    logic             code_ok;
    logic             start_ccc;
    logic             accept_byte;

    logic             upd_mwl;
    logic             upd_mrl;
    logic             upd_ibil;
    logic             upd_da;
    logic             da_valid_val;
    logic [6:0]       da_value;
    logic             drop_err;

    logic [15:0]      mwl_hold;
    logic [15:0]      mrl_hold;
    logic [7:0]       ibil_hold;
    logic [6:0]       da_hold;
    logic             da_valid_hold;

    assign code_ok   = is_supported(ccc_code_i);
    // A supported code restarts collection from any state; in COMMIT the
    // pending commit still completes because the decode uses registered state.
    assign start_ccc = ccc_valid_i && code_ok;
    // Direct CCCs only keep bytes addressed to this target.
    assign accept_byte = (state == ST_COLLECT) && !ccc_valid_i && data_valid_i &&
                         (!code[7] || direct_sel_i);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_ccc) begin
                    next_state = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (ccc_valid_i) begin
                    next_state = code_ok ? ST_COLLECT : ST_IDLE;
                end else if ((data_valid_i && data_last_i) || ccc_end_i) begin
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                next_state = start_ccc ? ST_COLLECT : ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Code latch, byte counter, payload buffer and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code     <= 8'd0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                payload[i] <= 8'd0;
            end
        end else if (start_ccc) begin
            code     <= ccc_code_i;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                payload[i] <= 8'd0;
            end
        end else if (accept_byte) begin
            if (count == CNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    if (count == CNT_W'(i)) begin
                        payload[i] <= data_i;
                    end
                end
                count <= count + CNT_ONE;
            end
        end
    end

    // Commit decode: which updates fire in the COMMIT cycle, or a reject
    always_comb begin
        upd_mwl      = 1'b0;
        upd_mrl      = 1'b0;
        upd_ibil     = 1'b0;
        upd_da       = 1'b0;
        da_valid_val = 1'b0;
        da_value     = 7'd0;
        drop_err     = 1'b0;
        // A direct CCC that never addressed this target is silently ignored.
        if ((state == ST_COMMIT) && !(code[7] && (count == '0) && !overflow)) begin
            if (overflow) begin
                drop_err = 1'b1;
            end else begin
                case (code)
                    CCC_SETMWL_B, CCC_SETMWL_D: begin
                        if (count == CNT_TWO) begin
                            upd_mwl = 1'b1;
                        end else begin
                            drop_err = 1'b1;
                        end
                    end
                    CCC_SETMRL_B, CCC_SETMRL_D: begin
                        if (count == CNT_TWO) begin
                            upd_mrl = 1'b1;
                        end else if (count == CNT_THREE) begin
                            upd_mrl  = 1'b1;
                            upd_ibil = 1'b1;
                        end else begin
                            drop_err = 1'b1;
                        end
                    end
                    CCC_SETDASA: begin
                        if ((count != CNT_ONE) || payload[0][0]) begin
                            drop_err = 1'b1;
                        end else if (target_sta_addr_valid_i && !target_dyn_addr_valid_i) begin
                            upd_da       = 1'b1;
                            da_valid_val = 1'b1;
                            da_value     = payload[0][7:1];
                        end
                    end
                    CCC_SETNEWDA: begin
                        if ((count != CNT_ONE) || payload[0][0]) begin
                            drop_err = 1'b1;
                        end else if (target_dyn_addr_valid_i) begin
                            upd_da       = 1'b1;
                            da_valid_val = 1'b1;
                            da_value     = payload[0][7:1];
                        end
                    end
                    CCC_RSTDAA: begin
                        if (count == '0) begin
                            upd_da = 1'b1;
                        end else begin
                            drop_err = 1'b1;
                        end
                    end
                    default: begin
                        drop_err = 1'b0;
                    end
                endcase
            end
        end
    end

    // Held copies of the value outputs, refreshed on each commit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mwl_hold      <= 16'd0;
            mrl_hold      <= 16'd0;
            ibil_hold     <= 8'd0;
            da_hold       <= 7'd0;
            da_valid_hold <= 1'b0;
        end else begin
            if (upd_mwl) begin
                mwl_hold <= {payload[0], payload[1]};
            end
            if (upd_mrl) begin
                mrl_hold <= {payload[0], payload[1]};
            end
            if (upd_ibil) begin
                ibil_hold <= payload[2];
            end
            if (upd_da) begin
                da_hold       <= da_value;
                da_valid_hold <= da_valid_val;
            end
        end
    end

    // Values are presented together with their strobe in the commit cycle.
    assign set_mwl_o        = upd_mwl;
    assign set_mrl_o        = upd_mrl;
    assign set_ibil_o       = upd_ibil;
    assign dyn_addr_we_o    = upd_da;
    assign ccc_err_o        = drop_err;
    assign mwl_o            = upd_mwl  ? {payload[0], payload[1]} : mwl_hold;
    assign mrl_o            = upd_mrl  ? {payload[0], payload[1]} : mrl_hold;
    assign ibil_o           = upd_ibil ? payload[2] : ibil_hold;
    assign dyn_addr_o       = upd_da   ? da_value : da_hold;
    assign dyn_addr_valid_o = upd_da   ? da_valid_val : da_valid_hold;
    assign busy_o           = (state == ST_COLLECT);

endmodule
`default_nettype wire
